// File: rtl/fft_tone_frame_gen_pkg.sv
// Shared definitions for the framed multi-tone FFT stimulus source:
// parameter defaults, FSM encoding and the offset-binary sine helpers.
package fft_tone_frame_gen_pkg;

  localparam int N_CH_DEF       = 2;
  localparam int ADDR_W_DEF     = 12;
  localparam int ROM_W_DEF      = 12;
  localparam int DATA_W_DEF     = 16;
  localparam int FRAME_LEN_DEF  = 1024;
  localparam int PHASE_INIT_DEF = 1024;

  // IDLE: no beats. RUN: samples being issued into the pipeline.
  // DRAIN: last sample of the final frame issued, waiting for its tlast handshake.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Offset-binary to two's complement: subtracting mid-scale is the same as
  // inverting the MSB of a w-bit code.
  function automatic int u2s(input int u, input int w);
    return u - (1 << (w - 1));
  endfunction

  // Unsigned offset-binary sine table entry for a given phase. The waveform is
  // a piecewise-parabolic sine approximation: each half period is
  // x*(half-x) scaled to full scale and clamped to the largest positive code.
  // Intended for ADDR_W <= 16 so the product stays inside 32 bits.
  function automatic int usin(input int phase, input int addr_w, input int rom_w);
    int half;
    int x;
    int y;
    int ymax;
    int mid;
    half = 1 << (addr_w - 1);
    x    = phase & (half - 1);
    y    = (x * (half - x)) >>> (2 * addr_w - 3 - rom_w);
    ymax = (1 << (rom_w - 1)) - 1;
    mid  = 1 << (rom_w - 1);
    if (y > ymax) y = ymax;
    if (phase >= half) return mid - y;
    return mid + y;
  endfunction

endpackage

// File: rtl/fft_tone_frame_gen_tone_channel.sv
// One tone channel: per-frame latched step and enable, phase accumulator
// addressing a registered sine table, signed sample output (0 when disabled).
module fft_tone_frame_gen_tone_channel
  import fft_tone_frame_gen_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int ROM_W      = ROM_W_DEF,
  parameter int PHASE_INIT = PHASE_INIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     step,
  input  logic                     adv,
  input  logic                     en_in,
  input  logic [ADDR_W-1:0]        delta_in,
  output logic signed [ROM_W-1:0]  sample
);

  localparam logic [ADDR_W-1:0] INIT = ADDR_W'(PHASE_INIT);

  logic [ADDR_W-1:0] acc_p0;
  logic [ADDR_W-1:0] delta_p0;
  logic              en_p0;
  logic [ROM_W-1:0]  rom_p1;
  logic              en_p1;

  // ---- stage p0: phase accumulator (ROM address) ----
  // Accumulator restarts at PHASE_INIT on every frame start and otherwise
  // steps once per issued sample, wrapping modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p0 <= INIT;
      en_p0  <= 1'b0;
    end else if (load) begin
      acc_p0 <= INIT;
      en_p0  <= en_in;
    end else if (step) begin
      acc_p0 <= acc_p0 + delta_p0;
    end
  end

  // Phase step is captured only at frame start so mid-frame changes wait.
  always_ff @(posedge clk) begin
    if (load) delta_p0 <= delta_in;
  end

  // ---- stage p1: registered sine table read ----
  // Read only on pipeline advance so the output stays stable during stalls.
  always_ff @(posedge clk) begin
    if (adv) rom_p1 <= ROM_W'(usin(int'(acc_p0), ADDR_W, ROM_W));
  end

  // Enable travels with the table data so a frame boundary switches cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     en_p1 <= 1'b0;
    else if (adv) en_p1 <= en_p0;
  end

  assign sample = en_p1 ? $signed(ROM_W'(u2s(int'(rom_p1), ROM_W))) : '0;

endmodule

// File: rtl/fft_tone_frame_gen.sv
// Framed multi-tone stimulus source: N_CH tone channels averaged into the
// real half of a valid/ready/last stream, imaginary half tied to zero.
module fft_tone_frame_gen
  import fft_tone_frame_gen_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int ROM_W      = ROM_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int PHASE_INIT = PHASE_INIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     stop,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH*ADDR_W-1:0]   delta,
  output logic [2*DATA_W-1:0]      m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic                     busy,
  output logic [15:0]              frame_cnt
);

  localparam int LOG_N = $clog2(N_CH);
  localparam int SUM_W = ROM_W + LOG_N;
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t state;
  state_t state_nxt;

  logic                    stop_flag;
  logic                    adv;
  logic                    issue;
  logic                    last_issue;
  logic                    more;
  logic                    start_go;
  logic                    frame_load;
  logic                    hs_last;
  logic [CNT_W-1:0]        cnt_p0;
  logic                    vld_p1;
  logic                    last_p1;
  logic signed [ROM_W-1:0] smp_p1 [N_CH];
  logic signed [SUM_W-1:0] sum_p1;

  // Floor average: arithmetic shift right by log2 of the channel count.
  function automatic logic signed [ROM_W-1:0] avg_fn(input logic signed [SUM_W-1:0] sum);
    logic signed [SUM_W-1:0] sh;
    sh = sum >>> LOG_N;
    return sh[ROM_W-1:0];
  endfunction

  // Place the ROM_W-bit average in the top bits of the DATA_W real half.
  function automatic logic [DATA_W-1:0] to_real(input logic signed [ROM_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = DATA_W'($unsigned(a));
    return w << (DATA_W - ROM_W);
  endfunction

  // The whole pipeline moves when the output register is empty or accepted.
  assign adv        = !m_tvalid || m_tready;
  assign issue      = (state == ST_RUN) && adv;
  assign last_issue = issue && (cnt_p0 == LAST_IDX);
  // The continue/stop decision is taken as the last sample of a frame enters
  // the pipeline, which lets the next frame follow its tlast with no bubble.
  assign more       = cont && !(stop_flag || stop);
  assign start_go   = (state == ST_IDLE) && start;
  assign frame_load = start_go || (last_issue && more);
  assign hs_last    = m_tvalid && m_tready && m_tlast;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM next state and busy flag.
  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (start)                state_nxt = ST_RUN;
      ST_RUN:   if (last_issue && !more)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (hs_last)              state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // Sticky stop request, armed only while a run is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          stop_flag <= 1'b0;
    else if (start_go)                 stop_flag <= 1'b0;
    else if (stop && state != ST_IDLE) stop_flag <= 1'b1;
  end

  // ---- stage p0: sample index within the frame ----
  // Counts issued samples; reset at every frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            cnt_p0 <= '0;
    else if (frame_load) cnt_p0 <= '0;
    else if (issue)      cnt_p0 <= cnt_p0 + 1'b1;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    fft_tone_frame_gen_tone_channel #(
      .ADDR_W     (ADDR_W),
      .ROM_W      (ROM_W),
      .PHASE_INIT (PHASE_INIT)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .load     (frame_load),
      .step     (issue),
      .adv      (adv),
      .en_in    (ch_en[k]),
      .delta_in (delta[k*ADDR_W +: ADDR_W]),
      .sample   (smp_p1[k])
    );
  end

  // ---- stage p1: table data valid, channel sum ----
  // Valid and last flags travel alongside the table read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1  <= issue;
      last_p1 <= last_issue;
    end
  end

  // Sign-extended sum of all channel samples (disabled channels give 0).
  always_comb begin
    sum_p1 = '0;
    for (int k = 0; k < N_CH; k++) sum_p1 = sum_p1 + SUM_W'(smp_p1[k]);
  end

  // ---- stage p2: output register ----
  // Output flags load on advance, so they hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (adv) begin
      m_tvalid <= vld_p1;
      m_tlast  <= last_p1;
    end
  end

  // Output sample {imag = 0, real = scaled average}, held during stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     m_tdata <= '0;
    else if (adv) m_tdata <= {{DATA_W{1'b0}}, to_real(avg_fn(sum_p1))};
  end

  // Completed frames, counted on each tlast handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         frame_cnt <= '0;
    else if (hs_last) frame_cnt <= frame_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fft_tone_frame_gen.sv
// Directed bench for fft_tone_frame_gen (N_CH=2, 12-bit phase, 1024-sample frames).
module tb_fft_tone_frame_gen;

  localparam int N_CH       = 2;
  localparam int ADDR_W     = 12;
  localparam int ROM_W      = 12;
  localparam int DATA_W     = 16;
  localparam int FRAME_LEN  = 1024;
  localparam int PHASE_INIT = 1024;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   cont;
  logic                   stop;
  logic [N_CH-1:0]        ch_en;
  logic [N_CH*ADDR_W-1:0] delta;
  logic [2*DATA_W-1:0]    m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;
  logic                   busy;
  logic [15:0]            frame_cnt;

  always #5 clk = ~clk;

  fft_tone_frame_gen #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .ROM_W(ROM_W), .DATA_W(DATA_W),
    .FRAME_LEN(FRAME_LEN), .PHASE_INIT(PHASE_INIT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .stop(stop),
    .ch_en(ch_en), .delta(delta), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t bq[$];
  beat_t ref1[$];

  int n_tests    = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int stall_n    = 0;
  int stall_bad  = 0;
  int gaps       = 0;
  int idle_beats = 0;
  int last_hs    = -1;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic        plast = 1'b0;
  logic [31:0] pdata = '0;
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: parabolic half-wave per half period, clamped, times 16.
  // mode 0: tone as is, 1: halved (floor), 2: silent.
  function automatic logic [31:0] model(input int p, input int mode);
    int x;
    int y;
    int s;
    x = (p >= 2048) ? p - 2048 : p;
    y = (x * (2048 - x)) / 512;
    if (y > 2047) y = 2047;
    s = (p >= 2048) ? -y : y;
    if (mode == 1) s = s >>> 1;
    if (mode == 2) s = 0;
    return {16'h0000, 16'(s * 16)};
  endfunction

  // Stream monitor: records handshakes, checks stall stability and gaps.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          stall_n++;
          if (!(m_tvalid === 1'b1 && m_tdata === pdata && m_tlast === plast)) stall_bad++;
        end
        if (m_tvalid && !busy) idle_beats++;
        if (m_tvalid && m_tready) begin
          bq.push_back('{data: m_tdata, last: m_tlast});
          if (last_hs >= 0 && cyc - last_hs != 1) gaps++;
          last_hs = cyc;
        end
        pv = m_tvalid; pr = m_tready; pdata = m_tdata; plast = m_tlast;
      end
    end
  end

  // Downstream ready: always 1, or a coin flip per cycle when rand_ready.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    bq.delete();
    stall_n = 0; stall_bad = 0; gaps = 0; last_hs = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (bq.size() < n && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
    if (bq.size() < n) check({tag, "_timeout"}, 64'(bq.size()), 64'(n));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int b;
    b = budget;
    while (busy && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  // Compare recorded beats with frames starting from PHASE_INIT; frame 0 uses
  // step0, later frames step1; tlast expected on beat 1023 of each frame only.
  task automatic check_stream(input string tag, input int nfr, input int step0,
                              input int step1, input int mode);
    int nbad;
    int f;
    int n;
    int st;
    int p;
    logic [31:0] ed;
    logic el;
    nbad = 0;
    check({tag, "_beats"}, 64'(bq.size()), 64'(nfr * 1024));
    for (int i = 0; i < bq.size(); i++) begin
      f  = i / 1024;
      n  = i % 1024;
      st = (f == 0) ? step0 : step1;
      p  = (1024 + n * st) % 4096;
      ed = model(p, mode);
      el = (n == 1023);
      if (bq[i].data !== ed || bq[i].last !== el) nbad++;
    end
    check({tag, "_bad"}, 64'(nbad), 64'(0));
  endtask

  task automatic run_single(input string tag, input logic [1:0] en, input int mode);
    clear_mon();
    ch_en = en;
    pulse_start();
    wait_beats(tag, 1024, 3000);
    wait_idle(tag, 50);
    repeat (5) @(posedge clk);
    #1;
    check_stream(tag, 1, 8, 8, mode);
  endtask

  initial begin
    int nbad;
    rst = 1'b0; start = 1'b0; cont = 1'b0; stop = 1'b0;
    ch_en = 2'b11; delta = {12'd1, 12'd1};
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_tlast", 64'(m_tlast), 64'(0));
    check("rst_tdata", 64'(m_tdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // T1: single frame, both channels step 1 (equivalent to one tone)
    clear_mon();
    pulse_start();
    check("t1_busy_on", 64'(busy), 64'(1));
    check("t1_vld_c0", 64'(m_tvalid), 64'(0));
    @(posedge clk); #1;
    check("t1_vld_c1", 64'(m_tvalid), 64'(0));
    @(posedge clk); #1;
    check("t1_vld_c2", 64'(m_tvalid), 64'(1));
    wait_beats("t1_mid", 100, 500);
    pulse_start();
    wait_beats("t1", 1024, 3000);
    wait_idle("t1", 50);
    repeat (10) @(posedge clk);
    #1;
    check_stream("t1", 1, 1, 1, 0);
    check("t1_beat0", 64'(bq[0].data), 64'h7FF0);
    check("t1_beat1023", {31'd0, bq[1023].last, bq[1023].data}, {31'd0, 1'b1, 32'h0000_0030});
    check("t1_frame_cnt", 64'(frame_cnt), 64'(1));
    check("t1_gaps", 64'(gaps), 64'(0));
    check("t1_tvalid_after", 64'(m_tvalid), 64'(0));
    ref1 = bq;

    // T2: same frame under random backpressure
    clear_mon();
    rand_ready = 1'b1;
    pulse_start();
    wait_beats("t2", 1024, 6000);
    wait_idle("t2", 200);
    rand_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    nbad = 0;
    for (int i = 0; i < bq.size() && i < ref1.size(); i++)
      if (bq[i].data !== ref1[i].data || bq[i].last !== ref1[i].last) nbad++;
    check("t2_beats", 64'(bq.size()), 64'(1024));
    check("t2_vs_t1", 64'(nbad), 64'(0));
    check("t2_stall_stable", 64'(stall_bad), 64'(0));
    check("t2_stalls_seen", 64'(stall_n > 0), 64'(1));
    check("t2_frame_cnt", 64'(frame_cnt), 64'(2));

    // T3: step 8, both / ch0 only / none enabled
    delta = {12'd8, 12'd8};
    run_single("t3_both", 2'b11, 0);
    check("t3_both_b64", 64'(bq[64].data), 64'h6000);
    check("t3_both_b128", 64'(bq[128].data), 64'h0000);
    run_single("t3_ch0", 2'b01, 1);
    check("t3_ch0_b0", 64'(bq[0].data), 64'h3FF0);
    run_single("t3_none", 2'b00, 2);
    check("t3_frame_cnt", 64'(frame_cnt), 64'(5));

    // T4: continuous, stop at beat 500 of frame 2
    ch_en = 2'b11; delta = {12'd1, 12'd1}; cont = 1'b1;
    clear_mon();
    pulse_start();
    wait_beats("t4_stop", 1524, 4000);
    pulse_stop();
    wait_beats("t4", 2048, 3000);
    wait_idle("t4", 100);
    repeat (20) @(posedge clk);
    #1;
    check_stream("t4", 2, 1, 1, 0);
    check("t4_gaps", 64'(gaps), 64'(0));
    check("t4_frame_cnt", 64'(frame_cnt), 64'(7));
    check("t4_tvalid_after", 64'(m_tvalid), 64'(0));

    // T5: delta 1 -> 4 mid frame 1, applies from frame 2
    clear_mon();
    pulse_start();
    wait_beats("t5_chg", 300, 1000);
    delta = {12'd4, 12'd4};
    wait_beats("t5_stop", 1100, 2000);
    pulse_stop();
    wait_beats("t5", 2048, 3000);
    wait_idle("t5", 100);
    cont = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_stream("t5", 2, 1, 4, 0);
    check("t5_gaps", 64'(gaps), 64'(0));
    check("t5_frame_cnt", 64'(frame_cnt), 64'(9));

    // T6: async reset mid-frame, then a fresh frame
    delta = {12'd1, 12'd1};
    clear_mon();
    pulse_start();
    wait_beats("t6_rst", 600, 2000);
    rst = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(m_tvalid), 64'(0));
    check("t6_rst_tlast", 64'(m_tlast), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_tdata", 64'(m_tdata), 64'(0));
    check("t6_rst_frame_cnt", 64'(frame_cnt), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    pulse_stop();
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle_stop_ignored", 64'(busy), 64'(0));
    pulse_start();
    wait_beats("t6", 1024, 3000);
    wait_idle("t6", 50);
    repeat (10) @(posedge clk);
    #1;
    check_stream("t6", 1, 1, 1, 0);
    check("t6_frame_cnt", 64'(frame_cnt), 64'(1));
    check("idle_beats", 64'(idle_beats), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
